// File: rtl/key_event_pkg.sv
// ----------------------------------------------------------------------------
// key_event_pkg
//
// Shared types and helpers for the key event classifier.
//   state_t      : gesture FSM states
//   ms_to_cycles : converts a duration in milliseconds to clock cycles
//   max_int      : larger of two integers, used to size the gesture timer
// ----------------------------------------------------------------------------
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED1,
        WAIT_GAP,
        PRESSED2,
        LONG_HELD
    } state_t;

    // Duration in milliseconds times 1000 times the clock rate in MHz gives
    // the cycle count the classifier compares against.
    function automatic int ms_to_cycles(input int ms, input int mhz);
        return ms * 1000 * mhz;
    endfunction

    // The single shared timer has to cover whichever window is longer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_classifier.sv
// ----------------------------------------------------------------------------
// key_event_classifier
//
// Sits behind the key debouncer and turns its transition strobes (press,
// release, press, ...) into gesture strobes: single click, double click and
// long press. Also exports the debounced key level.
//
// Ports:
//   clk_i              in   system clock
//   srst_i             in   synchronous reset, active-high
//   key_stb_i          in   one-cycle transition strobe (odd = press,
//                           even = release)
//   key_level_o        out  debounced key level, 1 = held
//   click_stb_o        out  one-cycle strobe per single click
//   double_click_stb_o out  one-cycle strobe per double click
//   long_press_stb_o   out  one-cycle strobe per long press
// ----------------------------------------------------------------------------
module key_event_classifier
    import key_event_pkg::*;
#(
    parameter int CLK_FREQ_MHZ  = 100,
    parameter int LONG_PRESS_MS = 1000,
    parameter int DOUBLE_GAP_MS = 300
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic key_stb_i,
    output logic key_level_o,
    output logic click_stb_o,
    output logic double_click_stb_o,
    output logic long_press_stb_o
);

    localparam int LONG_CYCLES = ms_to_cycles(LONG_PRESS_MS, CLK_FREQ_MHZ);
    localparam int GAP_CYCLES  = ms_to_cycles(DOUBLE_GAP_MS, CLK_FREQ_MHZ);
    localparam int MAX_CYCLES  = max_int(LONG_CYCLES, GAP_CYCLES);
    localparam int TIMER_W     = $clog2(MAX_CYCLES + 1);

    // The timer is cleared on the edge that enters a timed state, so in the
    // k-th cycle after the triggering strobe it reads k-1. The window closes
    // in the last cycle of the window, i.e. when it reads CYCLES-2, so that
    // the registered strobe lands exactly CYCLES cycles after the trigger.
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 2);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 2);

    // Both windows need at least two cycles for the expiry arithmetic above.
    generate
        if (LONG_CYCLES < 2) begin : gLongTooShort
            $fatal(1, "key_event_classifier: LONG_CYCLES must be >= 2");
        end
        if (GAP_CYCLES < 2) begin : gGapTooShort
            $fatal(1, "key_event_classifier: GAP_CYCLES must be >= 2");
        end
    endgenerate

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic                 keyLevel_q;
    logic                 clickStb_q;
    logic                 clickStb_d;
    logic                 doubleClickStb_q;
    logic                 doubleClickStb_d;
    logic                 longPressStb_q;
    logic                 longPressStb_d;
    logic                 longExpired;
    logic                 gapExpired;
    logic                 timedState;

    assign longExpired = (timer_q == LONG_LAST);
    assign gapExpired  = (timer_q == GAP_LAST);
    assign timedState  = (state_q == PRESSED1) || (state_q == WAIT_GAP) ||
                         (state_q == PRESSED2);

    // State register together with the gesture timer. Reset drops whatever
    // gesture was in flight; upstream is reset alongside, so the next strobe
    // is again a press.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic. In every timed state a strobe beats a simultaneous
    // expiry, so the strobe test comes first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (key_stb_i) state_d = PRESSED1;
            end
            PRESSED1: begin
                if (key_stb_i)        state_d = WAIT_GAP;
                else if (longExpired) state_d = LONG_HELD;
            end
            WAIT_GAP: begin
                if (key_stb_i)       state_d = PRESSED2;
                else if (gapExpired) state_d = IDLE;
            end
            PRESSED2: begin
                if (key_stb_i)        state_d = IDLE;
                else if (longExpired) state_d = LONG_HELD;
            end
            LONG_HELD: begin
                if (key_stb_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gesture timer. Any state change clears it, which covers entry to every
    // timed state. It only counts while a window is open, and each window
    // exits on expiry, so it never wraps.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q && timedState) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Output decode: the strobe values to register on this edge. A held
    // second tap reports both the first tap as a click and the hold as a
    // long press in the same cycle.
    always_comb begin
        clickStb_d       = 1'b0;
        doubleClickStb_d = 1'b0;
        longPressStb_d   = 1'b0;
        case (state_q)
            PRESSED1: begin
                if (!key_stb_i && longExpired) longPressStb_d = 1'b1;
            end
            WAIT_GAP: begin
                if (!key_stb_i && gapExpired) clickStb_d = 1'b1;
            end
            PRESSED2: begin
                if (key_stb_i) begin
                    doubleClickStb_d = 1'b1;
                end else if (longExpired) begin
                    clickStb_d     = 1'b1;
                    longPressStb_d = 1'b1;
                end
            end
            default: begin
                clickStb_d       = 1'b0;
                doubleClickStb_d = 1'b0;
                longPressStb_d   = 1'b0;
            end
        endcase
    end

    // Output registers. The key level simply flips on every transition
    // strobe, independent of the gesture state.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            keyLevel_q       <= 1'b0;
            clickStb_q       <= 1'b0;
            doubleClickStb_q <= 1'b0;
            longPressStb_q   <= 1'b0;
        end else begin
            keyLevel_q       <= keyLevel_q ^ key_stb_i;
            clickStb_q       <= clickStb_d;
            doubleClickStb_q <= doubleClickStb_d;
            longPressStb_q   <= longPressStb_d;
        end
    end

    assign key_level_o        = keyLevel_q;
    assign click_stb_o        = clickStb_q;
    assign double_click_stb_o = doubleClickStb_q;
    assign long_press_stb_o   = longPressStb_q;

endmodule

// File: tb/tb_key_event_classifier.sv
// ----------------------------------------------------------------------------
// tb_key_event_classifier
//
// Drives key_event_classifier with directed gesture sequences and random
// strobe trains, and compares every cycle against a gesture-level model
// built from strobe timestamps.
// ----------------------------------------------------------------------------
module tb_key_event_classifier;

    localparam int LONG   = 2000;
    localparam int GAP    = 1000;
    localparam int MAXLEN = 8192;

    logic clk;
    logic srst;
    logic keyStb;
    logic keyLevel;
    logic clickStb;
    logic doubleClickStb;
    logic longPressStb;

    int checks = 0;
    int errors = 0;

    int         stbQ[$];
    int         rstAt;
    int         scenLen;
    logic [3:0] expVec [MAXLEN];
    logic       stbAt  [MAXLEN];
    int         seenClick;
    int         seenDouble;
    int         seenLong;
    int         firstClick;
    int         firstDouble;
    int         firstLong;

    key_event_classifier #(
        .CLK_FREQ_MHZ (1),
        .LONG_PRESS_MS(2),
        .DOUBLE_GAP_MS(1)
    ) dut (
        .clk_i             (clk),
        .srst_i            (srst),
        .key_stb_i         (keyStb),
        .key_level_o       (keyLevel),
        .click_stb_o       (clickStb),
        .double_click_stb_o(doubleClickStb),
        .long_press_stb_o  (longPressStb)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record an expected gesture strobe if it falls inside the window.
    // Bit 2 = click, bit 1 = double click, bit 0 = long press.
    task automatic markEvent(input int cyc, input int bitIdx, input int wLo, input int wHi);
        if (cyc >= wLo && cyc <= wHi) expVec[cyc][bitIdx] = 1'b1;
    endtask

    // Gesture model: walks the strobe timestamps in [sLo,sHi] as
    // press/release pairs and decides each gesture from the time gaps alone.
    task automatic modelSegment(input int sLo, input int sHi, input int wLo, input int wHi);
        int s[$];
        int n;
        int i;
        int idx;
        int cnt;
        int p;
        int r;
        int p2;
        foreach (stbQ[k]) begin
            if (stbQ[k] >= sLo && stbQ[k] <= sHi) s.push_back(stbQ[k]);
        end
        n   = s.size();
        idx = 0;
        cnt = 0;
        for (int c = wLo; c <= wHi; c++) begin
            while (idx < n && s[idx] < c) begin
                cnt++;
                idx++;
            end
            expVec[c][3] = cnt[0];
        end
        i = 0;
        while (i < n) begin
            p = s[i];
            if (i + 1 >= n || s[i+1] - p > LONG - 1) begin
                markEvent(p + LONG, 0, wLo, wHi);
                i += 2;
            end else begin
                r = s[i+1];
                if (i + 2 >= n || s[i+2] - r > GAP - 1) begin
                    markEvent(r + GAP, 2, wLo, wHi);
                    i += 2;
                end else begin
                    p2 = s[i+2];
                    if (i + 3 >= n || s[i+3] - p2 > LONG - 1) begin
                        markEvent(p2 + LONG, 2, wLo, wHi);
                        markEvent(p2 + LONG, 0, wLo, wHi);
                    end else begin
                        markEvent(s[i+3] + 1, 1, wLo, wHi);
                    end
                    i += 4;
                end
            end
        end
    endtask

    // One comparison: counts it, and on a difference counts the failure.
    task automatic checkOutput(input string tag, input int cyc,
                               input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // Runs the current scenario: reset, then scenLen cycles checked each cycle.
    task automatic applyStimulus(input string name);
        logic [3:0] obs;
        for (int c = 0; c < MAXLEN; c++) begin
            expVec[c] = '0;
            stbAt[c]  = 1'b0;
        end
        foreach (stbQ[k]) stbAt[stbQ[k]] = 1'b1;
        if (rstAt < 0) begin
            modelSegment(0, scenLen - 1, 0, scenLen - 1);
        end else begin
            modelSegment(0, rstAt - 1, 0, rstAt);
            modelSegment(rstAt + 1, scenLen - 1, rstAt + 1, scenLen - 1);
        end
        seenClick   = 0;
        seenDouble  = 0;
        seenLong    = 0;
        firstClick  = -1;
        firstDouble = -1;
        firstLong   = -1;
        $display("[TB] scenario %s (%0d strobes, %0d cycles)", name, stbQ.size(), scenLen);
        srst   = 1'b1;
        keyStb = 1'b0;
        repeat (3) @(posedge clk);
        for (int c = 0; c < scenLen; c++) begin
            @(posedge clk);
            #1;
            obs = {keyLevel, clickStb, doubleClickStb, longPressStb};
            checkOutput(name, c, 32'(obs), 32'(expVec[c]));
            if (clickStb === 1'b1) begin
                if (firstClick < 0) firstClick = c;
                seenClick++;
            end
            if (doubleClickStb === 1'b1) begin
                if (firstDouble < 0) firstDouble = c;
                seenDouble++;
            end
            if (longPressStb === 1'b1) begin
                if (firstLong < 0) firstLong = c;
                seenLong++;
            end
            srst   = (c == rstAt);
            keyStb = stbAt[c] && (c != rstAt);
        end
    endtask

    // Builds a random strobe train with gaps clustered around the window
    // boundaries as well as very short gaps.
    task automatic randomTrain(input int len);
        int t;
        int d;
        int pick;
        stbQ.delete();
        t = int'($urandom_range(5, 40));
        while (t < len - 5) begin
            stbQ.push_back(t);
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       d = int'($urandom_range(1, 60));
                1:       d = int'($urandom_range(GAP - 2, GAP + 1));
                2:       d = int'($urandom_range(LONG - 2, LONG + 1));
                default: d = int'($urandom_range(1, 3));
            endcase
            t += d;
        end
    endtask

    initial begin
        srst   = 1'b1;
        keyStb = 1'b0;
        rstAt  = -1;

        stbQ = {10, 110};
        rstAt = -1; scenLen = 1200;
        applyStimulus("single_click");
        checkOutput("single_click_first", 0, 32'(firstClick), 32'd1110);
        checkOutput("single_click_count", 0, 32'(seenClick), 32'd1);
        checkOutput("single_click_others", 0, 32'(seenDouble + seenLong), 32'd0);

        stbQ = {10, 110, 500, 600};
        rstAt = -1; scenLen = 700;
        applyStimulus("double_click");
        checkOutput("double_click_first", 0, 32'(firstDouble), 32'd601);
        checkOutput("double_click_noclick", 0, 32'(seenClick), 32'd0);

        stbQ = {10, 110, 1109, 1200};
        rstAt = -1; scenLen = 1300;
        applyStimulus("gap_1109");
        checkOutput("gap_1109_double", 0, 32'(firstDouble), 32'd1201);
        checkOutput("gap_1109_noclick", 0, 32'(seenClick), 32'd0);

        stbQ = {10, 110, 1110, 1200};
        rstAt = -1; scenLen = 2300;
        applyStimulus("gap_1110");
        checkOutput("gap_1110_first", 0, 32'(firstClick), 32'd1110);
        checkOutput("gap_1110_count", 0, 32'(seenClick), 32'd2);
        checkOutput("gap_1110_nodouble", 0, 32'(seenDouble), 32'd0);

        stbQ = {10, 3000};
        rstAt = -1; scenLen = 3100;
        applyStimulus("long_press");
        checkOutput("long_press_first", 0, 32'(firstLong), 32'd2010);
        checkOutput("long_press_count", 0, 32'(seenLong + seenClick + seenDouble), 32'd1);

        stbQ = {10, 2009};
        rstAt = -1; scenLen = 3100;
        applyStimulus("long_boundary");
        checkOutput("long_boundary_nolong", 0, 32'(seenLong), 32'd0);
        checkOutput("long_boundary_click", 0, 32'(firstClick), 32'd3009);

        stbQ = {10, 110, 500};
        rstAt = -1; scenLen = 2600;
        applyStimulus("tap_hold");
        checkOutput("tap_hold_click", 0, 32'(firstClick), 32'd2500);
        checkOutput("tap_hold_long", 0, 32'(firstLong), 32'd2500);
        checkOutput("tap_hold_count", 0, 32'(seenClick + seenLong), 32'd2);

        stbQ = {10, 5010, 5020};
        rstAt = 50; scenLen = 6100;
        applyStimulus("reset_mid");
        checkOutput("reset_mid_nolong", 0, 32'(seenLong), 32'd0);
        checkOutput("reset_mid_click", 0, 32'(firstClick), 32'd6020);

        for (int n = 0; n < 4; n++) begin
            randomTrain(6000);
            rstAt = -1; scenLen = 6000;
            applyStimulus($sformatf("random_%0d", n));
        end

        randomTrain(6000);
        rstAt = int'($urandom_range(1500, 3500)); scenLen = 6000;
        applyStimulus("random_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
